ls_unit: RTL and testbench

LS_UNIT -- requirements
Module: ls_unit

---
 rtl/ls_unit_if.sv | 39 +++
 rtl/ls_unit.sv | 183 ++++++++++++++++++
 tb/tb_ls_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_unit_if.sv
// rtl/ls_unit_if.sv - issue, ROB, memory and result signals of the load/store unit
interface ls_unit_if;
    logic        rdy;
    logic        rollback;
    logic        in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [3:0]  in_rob_id;
    logic        in_ready;
    logic        rob_store_launch;
    logic [3:0]  rob_head_id;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        res_valid;
    logic [3:0]  res_rob_id;
    logic [31:0] res_value;
    logic [31:0] res_addr;

    modport slave (
        input  rdy, rollback, in_valid, in_op, in_rs1, in_rs2, in_imm, in_rob_id,
               rob_store_launch, rob_head_id, mem_done, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_size,
               res_valid, res_rob_id, res_value, res_addr
    );

    modport master (
        output rdy, rollback, in_valid, in_op, in_rs1, in_rs2, in_imm, in_rob_id,
               rob_store_launch, rob_head_id, mem_done, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_size,
               res_valid, res_rob_id, res_value, res_addr
    );
endinterface

// File: rtl/ls_unit.sv
// rtl/ls_unit.sv - single-entry load/store unit: loads go straight to memory, stores wait for ROB commit
module ls_unit #(
    parameter logic [5:0] OP_LB  = 6'd10,
    parameter logic [5:0] OP_LH  = 6'd11,
    parameter logic [5:0] OP_LW  = 6'd12,
    parameter logic [5:0] OP_LBU = 6'd13,
    parameter logic [5:0] OP_LHU = 6'd14,
    parameter logic [5:0] OP_SB  = 6'd15,
    parameter logic [5:0] OP_SH  = 6'd16,
    parameter logic [5:0] OP_SW  = 6'd17
) (
    input  logic       clk,
    input  logic       rst,
    ls_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_HOLD, STORE_WAIT} state_e;

    state_e      state_q, state_d;
    logic        discard_q, discard_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic [5:0]  op_q, op_d;
    logic [3:0]  tag_q, tag_d;
    logic [3:0]  res_tag_q, res_tag_d;
    logic [31:0] res_value_q, res_value_d;
    logic [31:0] res_addr_q, res_addr_d;

    logic [31:0] eff_addr;
    logic        is_load, is_store;
    logic [1:0]  in_size;
    logic [31:0] load_val;
    logic [31:0] wdata_masked;

    assign eff_addr = bus.in_rs1 + bus.in_imm;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        in_size  = 2'd2;
        case (bus.in_op)
            OP_LB, OP_LBU: begin is_load  = 1'b1; in_size = 2'd0; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; in_size = 2'd1; end
            OP_LW:         begin is_load  = 1'b1; in_size = 2'd2; end
            OP_SB:         begin is_store = 1'b1; in_size = 2'd0; end
            OP_SH:         begin is_store = 1'b1; in_size = 2'd1; end
            OP_SW:         begin is_store = 1'b1; in_size = 2'd2; end
            default: ;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_LB:   load_val = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
            OP_LH:   load_val = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            OP_LBU:  load_val = {24'd0, bus.mem_rdata[7:0]};
            OP_LHU:  load_val = {16'd0, bus.mem_rdata[15:0]};
            default: load_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    wdata_masked = {24'd0, data_q[7:0]};
            2'd1:    wdata_masked = {16'd0, data_q[15:0]};
            default: wdata_masked = data_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        discard_d   = discard_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        res_valid_d = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        size_d      = size_q;
        op_d        = op_q;
        tag_d       = tag_q;
        res_tag_d   = res_tag_q;
        res_value_d = res_value_q;
        res_addr_d  = res_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.rollback && (is_load || is_store)) begin
                    addr_d = eff_addr;
                    data_d = bus.in_rs2;
                    size_d = in_size;
                    op_d   = bus.in_op;
                    tag_d  = bus.in_rob_id;
                    if (is_load) begin
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        discard_d = 1'b0;
                        state_d   = LOAD_WAIT;
                    end else begin
                        // Store result is broadcast at issue; memory write waits for commit.
                        res_valid_d = 1'b1;
                        res_tag_d   = bus.in_rob_id;
                        res_value_d = bus.in_rs2;
                        res_addr_d  = eff_addr;
                        state_d     = STORE_HOLD;
                    end
                end
            end
            LOAD_WAIT: begin
                if (bus.rollback) discard_d = 1'b1;
                if (bus.mem_done) begin
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                    if (!discard_q && !bus.rollback) begin
                        res_valid_d = 1'b1;
                        res_tag_d   = tag_q;
                        res_value_d = load_val;
                        res_addr_d  = addr_q;
                    end
                end
            end
            STORE_HOLD: begin
                if (bus.rollback) begin
                    state_d = IDLE;
                end else if (bus.rob_store_launch && bus.rob_head_id == tag_q) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                    state_d   = STORE_WAIT;
                end
            end
            STORE_WAIT: begin
                if (bus.mem_done) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else if (bus.rdy) begin
            state_q     <= state_d;
            discard_q   <= discard_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.rdy) begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            size_q      <= size_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            res_tag_q   <= res_tag_d;
            res_value_q <= res_value_d;
            res_addr_q  <= res_addr_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_masked;
    assign bus.mem_size   = size_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_rob_id = res_tag_q;
    assign bus.res_value  = res_value_q;
    assign bus.res_addr   = res_addr_q;
endmodule

// File: tb/tb_ls_unit.sv
// tb/tb_ls_unit.sv - directed and randomized checks of ls_unit against a byte/half/word reference model
module tb_ls_unit;
    localparam logic [5:0] LB = 6'd10, LH = 6'd11, LW = 6'd12, LBU = 6'd13, LHU = 6'd14;
    localparam logic [5:0] SB = 6'd15, SH = 6'd16, SW = 6'd17;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    ls_unit_if bus ();
    ls_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [3:0] tag);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        bus.in_rob_id = tag;
    endtask

    function automatic logic [31:0] access_bytes(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 32'd1;
        if (op == LH || op == LHU || op == SH) return 32'd2;
        return 32'd4;
    endfunction

    function automatic logic [31:0] size_code(input logic [5:0] op);
        return access_bytes(op) / 2;
    endfunction

    // Reference load value: keep the low N bytes, and for signed kinds subtract 2^(8N) when the top bit is set.
    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] rd);
        logic [31:0] span, v;
        if (op == LW) return rd;
        span = (op == LB || op == LBU) ? 32'd256 : 32'd65536;
        v = rd % span;
        if ((op == LB || op == LH) && v >= span / 2) v = v - span;
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] d);
        if (op == SW) return d;
        return d % ((op == SB) ? 32'd256 : 32'd65536);
    endfunction

    task automatic run_load(input string nm, input logic [5:0] op, input logic [31:0] rs1,
                            input logic [31:0] imm, input logic [3:0] tag, input logic [31:0] rd,
                            input int waits);
        logic [31:0] ea;
        ea = rs1 + imm;
        issue(op, rs1, $urandom, imm, tag);
        tick();
        bus.in_valid = 1'b0;
        chk({nm, " req"}, 32'(bus.mem_req), 32'd1);
        chk({nm, " we"}, 32'(bus.mem_we), 32'd0);
        chk({nm, " addr"}, bus.mem_addr, ea);
        chk({nm, " size"}, 32'(bus.mem_size), size_code(op));
        chk({nm, " busy"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk({nm, " hold"}, 32'(bus.mem_req), 32'd1);
        end
        bus.mem_done  = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_done = 1'b0;
        chk({nm, " rv"}, 32'(bus.res_valid), 32'd1);
        chk({nm, " val"}, bus.res_value, model_load(op, rd));
        chk({nm, " tag"}, 32'(bus.res_rob_id), 32'(tag));
        chk({nm, " raddr"}, bus.res_addr, ea);
        chk({nm, " reqoff"}, 32'(bus.mem_req), 32'd0);
        chk({nm, " ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_store(input string nm, input logic [5:0] op, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] imm, input logic [3:0] tag);
        logic [31:0] ea;
        ea = rs1 + imm;
        issue(op, rs1, rs2, imm, tag);
        tick();
        bus.in_valid = 1'b0;
        chk({nm, " rv"}, 32'(bus.res_valid), 32'd1);
        chk({nm, " val"}, bus.res_value, rs2);
        chk({nm, " raddr"}, bus.res_addr, ea);
        chk({nm, " tag"}, 32'(bus.res_rob_id), 32'(tag));
        chk({nm, " noreq"}, 32'(bus.mem_req), 32'd0);
        bus.rob_store_launch = 1'b1;
        bus.rob_head_id      = tag + 4'd15;
        tick();
        chk({nm, " rvone"}, 32'(bus.res_valid), 32'd0);
        chk({nm, " wronghead"}, 32'(bus.mem_req), 32'd0);
        bus.rob_head_id = tag;
        tick();
        bus.rob_store_launch = 1'b0;
        chk({nm, " wreq"}, 32'(bus.mem_req), 32'd1);
        chk({nm, " we"}, 32'(bus.mem_we), 32'd1);
        chk({nm, " waddr"}, bus.mem_addr, ea);
        chk({nm, " wdata"}, bus.mem_wdata, model_wdata(op, rs2));
        chk({nm, " wsize"}, 32'(bus.mem_size), size_code(op));
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        chk({nm, " done"}, 32'(bus.mem_req), 32'd0);
        chk({nm, " norv"}, 32'(bus.res_valid), 32'd0);
        chk({nm, " ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [5:0] rop;
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.rollback = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = 6'd0;
        bus.in_rs1 = 32'd0;
        bus.in_rs2 = 32'd0;
        bus.in_imm = 32'd0;
        bus.in_rob_id = 4'd0;
        bus.rob_store_launch = 1'b0;
        bus.rob_head_id = 4'd0;
        bus.mem_done = 1'b0;
        bus.mem_rdata = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset ready", 32'(bus.in_ready), 32'd1);
        chk("reset req", 32'(bus.mem_req), 32'd0);
        chk("reset we", 32'(bus.mem_we), 32'd0);
        chk("reset rv", 32'(bus.res_valid), 32'd0);

        run_load("lw", LW, 32'h1000, 32'hFFFF_FFFC, 4'd3, 32'h8000_0001, 1);
        tick();
        chk("lw rv one cycle", 32'(bus.res_valid), 32'd0);
        run_load("lb", LB, 32'h20, 32'd1, 4'd1, 32'h0000_00F0, 0);
        run_load("lbu", LBU, 32'h20, 32'd2, 4'd2, 32'h0000_00F0, 0);
        run_load("lh", LH, 32'h40, 32'd3, 4'd4, 32'h0000_8001, 2);
        run_store("sh", SH, 32'h100, 32'h1234_5678, 32'd2, 4'd5);

        // Back-to-back: a load offered while the previous result is broadcast is accepted.
        run_load("b2b0", LHU, 32'h300, 32'd0, 4'd6, 32'hABCD_8765, 0);
        issue(LW, 32'h400, 32'd0, 32'd8, 4'd7);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b req", 32'(bus.mem_req), 32'd1);
        chk("b2b addr", bus.mem_addr, 32'h408);
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        chk("b2b rv", 32'(bus.res_valid), 32'd1);

        // Rollback while a load is outstanding: request held, result suppressed.
        issue(LW, 32'h500, 32'd0, 32'd0, 4'd8);
        tick();
        bus.in_valid = 1'b0;
        bus.rollback = 1'b1;
        tick();
        bus.rollback = 1'b0;
        chk("rbload held", 32'(bus.mem_req), 32'd1);
        tick();
        chk("rbload held2", 32'(bus.mem_req), 32'd1);
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        chk("rbload norv", 32'(bus.res_valid), 32'd0);
        chk("rbload reqoff", 32'(bus.mem_req), 32'd0);
        chk("rbload idle", 32'(bus.in_ready), 32'd1);

        // Rollback in STORE_HOLD drops the store.
        issue(SW, 32'h600, 32'hDEAD_BEEF, 32'd0, 4'd9);
        tick();
        bus.in_valid = 1'b0;
        bus.rollback = 1'b1;
        tick();
        bus.rollback = 1'b0;
        chk("rbhold idle", 32'(bus.in_ready), 32'd1);
        bus.rob_store_launch = 1'b1;
        bus.rob_head_id = 4'd9;
        tick();
        bus.rob_store_launch = 1'b0;
        chk("rbhold nowrite", 32'(bus.mem_req), 32'd0);

        // Rollback in STORE_WAIT is ignored.
        issue(SB, 32'h700, 32'h0000_01A5, 32'd1, 4'd10);
        tick();
        bus.in_valid = 1'b0;
        bus.rob_store_launch = 1'b1;
        bus.rob_head_id = 4'd10;
        tick();
        bus.rob_store_launch = 1'b0;
        bus.rollback = 1'b1;
        tick();
        bus.rollback = 1'b0;
        chk("rbwait req", 32'(bus.mem_req), 32'd1);
        chk("rbwait wdata", bus.mem_wdata, 32'h0000_00A5);
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        chk("rbwait idle", 32'(bus.in_ready), 32'd1);

        // Accept and rollback together: accept dropped.
        issue(SW, 32'h800, 32'h1, 32'd0, 4'd11);
        bus.rollback = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.rollback = 1'b0;
        chk("rbaccept rv", 32'(bus.res_valid), 32'd0);
        chk("rbaccept idle", 32'(bus.in_ready), 32'd1);

        // Unknown opcode.
        issue(6'd5, 32'h900, 32'h1, 32'd0, 4'd12);
        tick();
        bus.in_valid = 1'b0;
        chk("badop req", 32'(bus.mem_req), 32'd0);
        chk("badop rv", 32'(bus.res_valid), 32'd0);
        chk("badop idle", 32'(bus.in_ready), 32'd1);

        // rdy low freezes state.
        issue(LW, 32'hA00, 32'd0, 32'd0, 4'd13);
        tick();
        bus.in_valid = 1'b0;
        bus.rdy = 1'b0;
        bus.mem_done = 1'b1;
        tick();
        tick();
        chk("rdy hold req", 32'(bus.mem_req), 32'd1);
        chk("rdy hold rv", 32'(bus.res_valid), 32'd0);
        bus.rdy = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        chk("rdy resume rv", 32'(bus.res_valid), 32'd1);

        // Reset mid-transaction abandons the load.
        issue(LW, 32'hB00, 32'd0, 32'd0, 4'd14);
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid req", 32'(bus.mem_req), 32'd0);
        chk("rstmid idle", 32'(bus.in_ready), 32'd1);
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        chk("rstmid norv", 32'(bus.res_valid), 32'd0);

        for (int n = 0; n < 40; n++) begin
            rop = 6'(10 + $urandom_range(0, 7));
            if (rop >= SB)
                run_store("rnd st", rop, $urandom, $urandom, $urandom, 4'($urandom));
            else
                run_load("rnd ld", rop, $urandom, $urandom, 4'($urandom), $urandom,
                         int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
